mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Shares one output channel between two valid/ready requesters (A, B) by
//  sequencing a 2:1 mux select. Round-robin arbitration with bounded bursts
//  and a registered output stage. Sits upstream of any single-consumer sink
//  fed by two producers.
// PARAMETERS
//  W          8   data width of a_data, b_data, out_data
//  MAX_BURST  4   max beats accepted per grant before arbitration reopens (>=1)
// PORTS
//  clk        in   1  sole clock, rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  a_valid    in   1  requester A has data
//  a_data     in   W  requester A payload
//  a_ready    out  1  A beat accepted this cycle when a_valid&a_ready
//  b_valid    in   1  requester B has data
//  b_data     in   W  requester B payload
//  b_ready    out  1  B beat accepted this cycle when b_valid&b_ready
//  out_valid  out  1  output register holds a beat
//  out_data   out  W  output payload
//  out_ready  in   1  sink accepts beat when out_valid&out_ready
//  sel        out  1  current mux select/grant: 0=A, 1=B (registered)
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, last_sel=1 (A wins first tie), beat_cnt=0,
//   out_valid=0, out_data=0, a_ready=b_ready=0.
//  FSM states IDLE, GNT_A, GNT_B; all transitions on clk rising edge.
//  IDLE: only A valid->GNT_A; only B valid->GNT_B; both->side != last_sel;
//   none->IDLE. No beat accepted in IDLE (1-cycle arbitration bubble).
//  space = !out_valid | out_ready (output reg empty or draining this cycle).
//  a_ready = (state==GNT_A)&space; b_ready = (state==GNT_B)&space (comb).
//  Accept: granted valid&ready -> out_data<=granted data, out_valid<=1,
//   beat_cnt++. Else if out_ready -> out_valid<=0. Latency 1 cycle in->out.
//  GNT_x release when (beat accepted and beat_cnt==MAX_BURST-1) or x_valid==0:
//   last_sel<=x, beat_cnt<=0; other valid -> GNT_other directly (no bubble);
//   else x_valid -> GNT_x new burst; else IDLE.
//  Releasing on the same edge as the final beat: that beat is still accepted.
//  sel updates with state; holds last value in IDLE.
//  Requester dropping valid mid-burst: legal, releases grant next edge.
//  out_valid held with out_ready=0: out_data stable, no grantee ready.
//  rst_n low mid-burst: immediate return to reset values; in-flight beat lost.
// CONFIGURATION
//  MUX2_ARB_PRIO_EN defined: adds input port prio_a (1 bit); when 1, A wins
//   every tie in IDLE and at burst release regardless of last_sel; when 0,
//   round-robin as above. MAX_BURST still bounds each A burst.
//  Undefined: no prio_a port; pure round-robin.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0, sel=0 at once.
//  2 Single source: A sends 8'h11..8'h16 continuously, out_ready=1 -> out_data
//    same order, each 1 cycle after accept; re-arb after 4th beat, A regranted.
//  3 Tie: A,B both valid from reset -> A gets 4 beats, B gets 4 beats, then
//    A; sel toggles 0->1->0; no bubble between bursts.
//  4 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> a_ready=0,
//    out_data stable; out_ready=1 -> next beat accepted same cycle.
//  5 Early drop: B valid for 2 beats then drops, A valid -> grant to A next edge,
//    beat_cnt restarts at 0.
//  6 MUX2_ARB_PRIO_EN, prio_a=1, both valid -> A wins every release; B only
//    served when a_valid=0; prio_a=0 -> alternating bursts.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-requester valid/ready arbiter: round-robin bursts of up to MAX_BURST beats into one registered output.
// Latency 1 cycle from accept to out_valid; a requester is ready only when granted and the output reg has space.
// Define MUX2_ARB_PRIO_EN to add prio_a, which makes A win every tie.
module mux2_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MUX2_ARB_PRIO_EN
    input  logic         prio_a,
`endif
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         sel
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t          state_q;
    logic            sel_q;
    logic            last_sel_q;
    logic [CW-1:0]   beat_cnt_q;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;

    logic            space;
    logic            accept;
    logic            burst_done;
    logic            prio_on;
    logic [W-1:0]    grant_data;

`ifdef MUX2_ARB_PRIO_EN
    assign prio_on = prio_a;
`else
    assign prio_on = 1'b0;
`endif

    assign space      = !out_valid_q || out_ready;
    assign a_ready    = (state_q == GNT_A) && space;
    assign b_ready    = (state_q == GNT_B) && space;
    assign accept     = (a_valid && a_ready) || (b_valid && b_ready);
    assign burst_done = accept && (beat_cnt_q == LAST_BEAT);
    assign grant_data = (state_q == GNT_B) ? b_data : a_data;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_sel_q  <= 1'b1;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                out_data_q  <= grant_data;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // last_sel_q==1 means B was served last, so A takes the tie
                    if (a_valid && (!b_valid || prio_on || last_sel_q)) begin
                        state_q <= GNT_A;
                        sel_q   <= 1'b0;
                    end else if (b_valid) begin
                        state_q <= GNT_B;
                        sel_q   <= 1'b1;
                    end
                end
                GNT_A: begin
                    if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (burst_done || !a_valid) begin
                        beat_cnt_q <= '0;
                        last_sel_q <= 1'b0;
                        if (b_valid && !(prio_on && a_valid)) begin
                            state_q <= GNT_B;
                            sel_q   <= 1'b1;
                        end else if (a_valid) begin
                            state_q <= GNT_A;
                            sel_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GNT_B: begin
                    if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (burst_done || !b_valid) begin
                        beat_cnt_q <= '0;
                        last_sel_q <= 1'b1;
                        if (a_valid) begin
                            state_q <= GNT_A;
                            sel_q   <= 1'b0;
                        end else if (b_valid) begin
                            state_q <= GNT_B;
                            sel_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: vector table plus hand sequences for
// asynchronous reset, early drop and (when built with it) A priority.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prio_a;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, sel;
    logic [7:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX2_ARB_PRIO_EN
        .prio_a    (prio_a),
`endif
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ar;
        logic       br;
        logic       ov;
        logic [7:0] od;
        logic       sel;
    } vec_t;

    vec_t tbl [0:21];

    function automatic vec_t mk(logic rst, logic av, logic [7:0] ad, logic bv, logic [7:0] bd,
                                logic ordy, logic ar, logic br, logic ov, logic [7:0] od, logic s);
        vec_t v;
        v.rst = rst; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.ar = ar; v.br = br; v.ov = ov; v.od = od; v.sel = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+2: drive, check comb readies, then registered outputs after the edge
    task automatic cyc(input string tag, input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic ordy, input logic ar, input logic br,
                       input logic ov, input logic [7:0] od, input logic s);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #2;
        chk({tag, ".a_ready"}, {7'd0, a_ready}, {7'd0, ar});
        chk({tag, ".b_ready"}, {7'd0, b_ready}, {7'd0, br});
        @(posedge clk);
        #2;
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
        chk({tag, ".out_data"}, out_data, od);
        chk({tag, ".sel"}, {7'd0, sel}, {7'd0, s});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, ".out_data"}, out_data, 8'd0);
        chk({tag, ".sel"}, {7'd0, sel}, 8'd0);
        chk({tag, ".a_ready"}, {7'd0, a_ready}, 8'd0);
        chk({tag, ".b_ready"}, {7'd0, b_ready}, 8'd0);
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; prio_a = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;

        // Single source A, MAX_BURST=4: A regranted after 4th beat without a bubble
        tbl[0]  = mk(1, 1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0);
        tbl[2]  = mk(0, 1, 8'h12, 0, 8'h00, 1, 1, 0, 1, 8'h12, 0);
        tbl[3]  = mk(0, 1, 8'h13, 0, 8'h00, 1, 1, 0, 1, 8'h13, 0);
        tbl[4]  = mk(0, 1, 8'h14, 0, 8'h00, 1, 1, 0, 1, 8'h14, 0);
        tbl[5]  = mk(0, 1, 8'h15, 0, 8'h00, 1, 1, 0, 1, 8'h15, 0);
        tbl[6]  = mk(0, 1, 8'h16, 0, 8'h00, 1, 1, 0, 1, 8'h16, 0);
        tbl[7]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h16, 0);
        // Tie from reset: 4 A, 4 B, back to A, then 3 cycles of backpressure
        tbl[8]  = mk(1, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0);
        tbl[9]  = mk(0, 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0);
        tbl[10] = mk(0, 1, 8'hA1, 1, 8'hB0, 1, 1, 0, 1, 8'hA1, 0);
        tbl[11] = mk(0, 1, 8'hA2, 1, 8'hB0, 1, 1, 0, 1, 8'hA2, 0);
        tbl[12] = mk(0, 1, 8'hA3, 1, 8'hB0, 1, 1, 0, 1, 8'hA3, 1);
        tbl[13] = mk(0, 1, 8'hA4, 1, 8'hB0, 1, 0, 1, 1, 8'hB0, 1);
        tbl[14] = mk(0, 1, 8'hA4, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1);
        tbl[15] = mk(0, 1, 8'hA4, 1, 8'hB2, 1, 0, 1, 1, 8'hB2, 1);
        tbl[16] = mk(0, 1, 8'hA4, 1, 8'hB3, 1, 0, 1, 1, 8'hB3, 0);
        tbl[17] = mk(0, 1, 8'hA4, 1, 8'hB4, 1, 1, 0, 1, 8'hA4, 0);
        tbl[18] = mk(0, 1, 8'hA5, 1, 8'hB4, 0, 0, 0, 1, 8'hA4, 0);
        tbl[19] = mk(0, 1, 8'hA5, 1, 8'hB4, 0, 0, 0, 1, 8'hA4, 0);
        tbl[20] = mk(0, 1, 8'hA5, 1, 8'hB4, 0, 0, 0, 1, 8'hA4, 0);
        tbl[21] = mk(0, 1, 8'hA5, 1, 8'hB4, 1, 1, 0, 1, 8'hA5, 0);

        @(posedge clk);
        #2;
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) do_reset();
            cyc($sformatf("vec%0d", i), tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy,
                tbl[i].ar, tbl[i].br, tbl[i].ov, tbl[i].od, tbl[i].sel);
        end

        // Asynchronous reset mid-burst, between clock edges, with A still requesting
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // B drops after 2 beats: A granted at once, and gets a full 4-beat burst
        do_reset();
        cyc("drop0", 0, 8'h00, 1, 8'hC0, 1, 0, 0, 0, 8'h00, 1);
        cyc("drop1", 0, 8'h00, 1, 8'hC0, 1, 0, 1, 1, 8'hC0, 1);
        cyc("drop2", 0, 8'h00, 1, 8'hC1, 1, 0, 1, 1, 8'hC1, 1);
        cyc("drop3", 1, 8'hD0, 0, 8'hC2, 1, 0, 1, 0, 8'hC1, 0);
        cyc("drop4", 1, 8'hD0, 1, 8'hC2, 1, 1, 0, 1, 8'hD0, 0);
        cyc("drop5", 1, 8'hD1, 1, 8'hC2, 1, 1, 0, 1, 8'hD1, 0);
        cyc("drop6", 1, 8'hD2, 1, 8'hC2, 1, 1, 0, 1, 8'hD2, 0);
        cyc("drop7", 1, 8'hD3, 1, 8'hC2, 1, 1, 0, 1, 8'hD3, 1);

`ifdef MUX2_ARB_PRIO_EN
        // A priority: A regranted at release despite B waiting; B only once A idles
        do_reset();
        prio_a = 1'b1;
        cyc("prio0", 1, 8'h50, 1, 8'h60, 1, 0, 0, 0, 8'h00, 0);
        cyc("prio1", 1, 8'h50, 1, 8'h60, 1, 1, 0, 1, 8'h50, 0);
        cyc("prio2", 1, 8'h51, 1, 8'h60, 1, 1, 0, 1, 8'h51, 0);
        cyc("prio3", 1, 8'h52, 1, 8'h60, 1, 1, 0, 1, 8'h52, 0);
        cyc("prio4", 1, 8'h53, 1, 8'h60, 1, 1, 0, 1, 8'h53, 0);
        cyc("prio5", 1, 8'h54, 1, 8'h60, 1, 1, 0, 1, 8'h54, 0);
        cyc("prio6", 0, 8'h00, 1, 8'h60, 1, 1, 0, 0, 8'h54, 1);
        cyc("prio7", 0, 8'h00, 1, 8'h60, 1, 0, 1, 1, 8'h60, 1);
        prio_a = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
